// File: rtl/skinny_mask_pkg.sv
// Shared definitions for the masked SKINNY S-box affine layer.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package skinny_mask_pkg;

    localparam int SHARES = 3;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        AFF_A1   = 2'd0,
        AFF_A2   = 2'd1,
        AFF_ID   = 2'd2,
        AFF_A2A1 = 2'd3
    } aff_mode_e;

    // Linear (bit-permutation) part of each map; x[k] is bit k of the nibble.
    function automatic logic [NIB_W-1:0] aff_perm(input aff_mode_e m, input logic [NIB_W-1:0] x);
        logic [NIB_W-1:0] r;
        case (m)
            AFF_A1:   r = {x[0], x[1], x[2], x[3]};
            AFF_A2:   r = {x[3], x[2], x[0], x[1]};
            AFF_A2A1: r = {x[1], x[0], x[2], x[3]};
            default:  r = x;
        endcase
        return r;
    endfunction

    // Maps whose affine constant is all-ones. Only one share may carry the
    // constant, otherwise the XOR of the shares would be wrong.
    function automatic logic aff_flips(input aff_mode_e m);
        return (m == AFF_A2) || (m == AFF_A2A1);
    endfunction

endpackage

// File: rtl/masked_affine_nibble.sv
// One-nibble, three-share affine map; shares are processed independently.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: mode - selected map; x1/x2/x3 - input shares; y1/y2/y3 - output shares.
module masked_affine_nibble
    import skinny_mask_pkg::*;
(
    input  aff_mode_e        mode,
    input  logic [NIB_W-1:0] x1,
    input  logic [NIB_W-1:0] x2,
    input  logic [NIB_W-1:0] x3,
    output logic [NIB_W-1:0] y1,
    output logic [NIB_W-1:0] y2,
    output logic [NIB_W-1:0] y3
);

    logic flip;

    assign flip = aff_flips(mode);

    // The constant lands on share 1 only; shares 2 and 3 see the linear part.
    assign y1 = aff_perm(mode, x1) ^ {NIB_W{flip}};
    assign y2 = aff_perm(mode, x2);
    assign y3 = aff_perm(mode, x3);

endmodule

// File: rtl/masked_affine_pipe.sv
// Pipelined 3-share nibble-wise affine layer with explicit or auto-sequenced mode.
// Latency: STAGES cycles from accept to out_valid; 1 beat/cycle when out_ready=1.
// Backpressure: whole pipe freezes when the output beat is not taken; in_ready=out_ready|~out_valid.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_first/mode_auto/mode_sel and x1..x3
//        on the input side; out_valid/out_ready, y1..y3 and out_mode on the output side.
module masked_affine_pipe
    import skinny_mask_pkg::*;
#(
    parameter int NIBBLES = 1,
    parameter int STAGES  = 1,
    parameter int SEQ_LEN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     mode_auto,
    input  logic [1:0]               mode_sel,
    input  logic [NIB_W*NIBBLES-1:0] x1,
    input  logic [NIB_W*NIBBLES-1:0] x2,
    input  logic [NIB_W*NIBBLES-1:0] x3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NIBBLES-1:0] y1,
    output logic [NIB_W*NIBBLES-1:0] y2,
    output logic [NIB_W*NIBBLES-1:0] y3,
    output logic [1:0]               out_mode
);

    localparam int         W     = NIB_W * NIBBLES;
    localparam logic [2:0] SEQ_L = 3'(SEQ_LEN);

    typedef struct packed {
        aff_mode_e                mode;
        logic [SHARES-1:0][W-1:0] sh;
    } beat_t;

    logic [1:0]        cnt;
    logic [2:0]        cnt_inc;
    logic [1:0]        cnt_nxt;
    aff_mode_e         mode_use;
    logic              en;
    logic              accept;
    logic [W-1:0]      a1;
    logic [W-1:0]      a2;
    logic [W-1:0]      a3;
    beat_t             beat_in;
    beat_t             pipe [STAGES];
    logic [STAGES-1:0] vld;

    // in_first only restarts the sequence in auto mode.
    always_comb begin
        mode_use = aff_mode_e'(mode_sel);
        if (mode_auto) begin
            mode_use = in_first ? AFF_A1 : aff_mode_e'(cnt);
        end
    end

    // In auto mode the used step is always < SEQ_LEN, so step+1 can at most
    // reach SEQ_LEN and a single compare implements the modulo.
    assign cnt_inc = {1'b0, mode_use} + 3'd1;
    assign cnt_nxt = (cnt_inc >= SEQ_L) ? 2'd0 : cnt_inc[1:0];

    assign en       = out_ready | ~vld[STAGES-1];
    assign in_ready = en;
    assign accept   = in_valid & en;

    for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
        masked_affine_nibble u_nib (
            .mode (mode_use),
            .x1   (x1[g*NIB_W +: NIB_W]),
            .x2   (x2[g*NIB_W +: NIB_W]),
            .x3   (x3[g*NIB_W +: NIB_W]),
            .y1   (a1[g*NIB_W +: NIB_W]),
            .y2   (a2[g*NIB_W +: NIB_W]),
            .y3   (a3[g*NIB_W +: NIB_W])
        );
    end

    always_comb begin
        beat_in       = '0;
        beat_in.mode  = mode_use;
        beat_in.sh[0] = a1;
        beat_in.sh[1] = a2;
        beat_in.sh[2] = a3;
    end

    // Data is registered even for bubbles; only vld tells them apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (accept && mode_auto) begin
                cnt <= cnt_nxt;
            end
            if (en) begin
                vld[0]  <= accept;
                pipe[0] <= beat_in;
                for (int i = 1; i < STAGES; i++) begin
                    vld[i]  <= vld[i-1];
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign y1        = pipe[STAGES-1].sh[0];
    assign y2        = pipe[STAGES-1].sh[1];
    assign y3        = pipe[STAGES-1].sh[2];
    assign out_mode  = pipe[STAGES-1].mode;

endmodule

// File: tb/tb_masked_affine_pipe.sv
// Scoreboard bench for masked_affine_pipe (NIBBLES=4, STAGES=3, SEQ_LEN=2).
// Latency: n/a.
// Backpressure: bench drives out_ready fixed or randomly.
module tb_masked_affine_pipe;

    localparam int NIB = 4;
    localparam int STG = 3;
    localparam int SEQ = 2;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic         mode_auto;
    logic [1:0]   mode_sel;
    logic [W-1:0] x1, x2, x3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y1, y2, y3;
    logic [1:0]   out_mode;

    always #5 clk = ~clk;

    masked_affine_pipe #(.NIBBLES(NIB), .STAGES(STG), .SEQ_LEN(SEQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .mode_auto (mode_auto),
        .mode_sel  (mode_sel),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .out_mode  (out_mode)
    );

    typedef struct {
        logic [1:0]   m;
        logic [W-1:0] e1, e2, e3;
        logic [W-1:0] xx;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   nvec = 0;
    int   nerr = 0;
    int   bcnt = 0;

    // Golden per-nibble map written from the bit-order definitions.
    function automatic logic [3:0] gnib(input int m, input logic [3:0] n, input bit s1);
        logic [3:0] r;
        case (m)
            0:       r = {n[0], n[1], n[2], n[3]};
            1:       r = {n[3], n[2], n[0], n[1]};
            3:       r = {n[1], n[0], n[2], n[3]};
            default: r = n;
        endcase
        if (s1 && (m == 1 || m == 3)) r = ~r;
        return r;
    endfunction

    function automatic logic [W-1:0] gvec(input int m, input logic [W-1:0] x, input bit s1);
        logic [W-1:0] r;
        r = '0;
        for (int n = 0; n < NIB; n++) r[n*4 +: 4] = gnib(m, x[n*4 +: 4], s1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Offer one beat until accepted; pushes the expected response on accept.
    task automatic beat(input bit first, input bit auto, input logic [1:0] sel,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input bit hand, input logic [W-1:0] h1, input logic [W-1:0] h2,
                        input logic [W-1:0] h3, input logic [1:0] hm, input int ordy);
        bit   done;
        int   tries;
        int   mu;
        exp_t e;
        done  = 1'b0;
        tries = 0;
        while (!done) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_first  = first;
            mode_auto = auto;
            mode_sel  = sel;
            x1 = a; x2 = b; x3 = c;
            out_ready = (ordy == 2) ? ($urandom_range(0, 3) != 0) : (ordy == 1);
            @(negedge clk);
            if (in_ready) begin
                mu = auto ? (first ? 0 : bcnt) : int'(sel);
                if (auto) bcnt = (mu + 1) % SEQ;
                if (hand) begin
                    e.m = hm; e.e1 = h1; e.e2 = h2; e.e3 = h3;
                end else begin
                    e.m  = 2'(mu);
                    e.e1 = gvec(mu, a, 1'b1);
                    e.e2 = gvec(mu, b, 1'b0);
                    e.e3 = gvec(mu, c, 1'b0);
                end
                e.xx = a ^ b ^ c;
                q.push_back(e);
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 100) begin
                    nvec++; nerr++;
                    $display("FAIL accept_timeout actual=in_ready_low required=accept");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        int k;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain actual=%0d_pending required=0", q.size());
        end
    endtask

    // Monitor: compares every completed output handshake against the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL extra_beat actual=y1_%h required=no_beat", y1);
            end else begin
                mon_e = q.pop_front();
                chk("y1", y1, mon_e.e1);
                chk("y2", y2, mon_e.e2);
                chk("y3", y3, mon_e.e3);
                chk("out_mode", 16'(out_mode), 16'(mon_e.m));
                chk("share_xor", y1 ^ y2 ^ y3, gvec(int'(mon_e.m), mon_e.xx, 1'b1));
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; mode_auto = 1'b0; mode_sel = 2'd0;
        x1 = '0; x2 = '0; x3 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_y1", y1, 16'h0);
        chk("rst_y2", y2, 16'h0);
        chk("rst_y3", y3, 16'h0);
        chk("rst_out_mode", 16'(out_mode), 16'd0);

        // Mode 0 vector and accept-to-valid latency.
        beat(0, 0, 2'd0, 16'h1111, 16'h3333, 16'h8888, 1, 16'h8888, 16'hCCCC, 16'h1111, 2'd0, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
        end
        chk("latency", 16'(k), 16'(STG));
        drain();

        // Mode 1 vector and a mode 3 vector.
        beat(0, 0, 2'd1, 16'h1111, 16'h1111, 16'h0000, 1, 16'hDDDD, 16'h2222, 16'h0000, 2'd1, 1);
        beat(0, 0, 2'd3, 16'h1111, 16'h3333, 16'h8888, 1, 16'hBBBB, 16'hCCCC, 16'h1111, 2'd3, 1);
        drain();

        // Auto sequence: in_first 1,0,0,1,0 -> modes 0,1,0,0,1.
        beat(1, 1, 2'd3, 16'h1111, 16'h3333, 16'h8888, 1, 16'h8888, 16'hCCCC, 16'h1111, 2'd0, 1);
        beat(0, 1, 2'd3, 16'h1111, 16'h3333, 16'h8888, 1, 16'hDDDD, 16'h3333, 16'h8888, 2'd1, 1);
        beat(0, 1, 2'd3, 16'h1111, 16'h3333, 16'h8888, 1, 16'h8888, 16'hCCCC, 16'h1111, 2'd0, 1);
        beat(1, 1, 2'd3, 16'h1111, 16'h3333, 16'h8888, 1, 16'h8888, 16'hCCCC, 16'h1111, 2'd0, 1);
        beat(0, 1, 2'd3, 16'h1111, 16'h3333, 16'h8888, 1, 16'hDDDD, 16'h3333, 16'h8888, 2'd1, 1);
        drain();

        // All 4096 share triples through mode 1, four per beat.
        for (int j = 0; j < 1024; j++) begin
            logic [W-1:0] a, b, c;
            for (int n = 0; n < NIB; n++) begin
                logic [11:0] t;
                t = 12'(j * NIB + n);
                a[n*4 +: 4] = t[3:0];
                b[n*4 +: 4] = t[7:4];
                c[n*4 +: 4] = t[11:8];
            end
            beat(0, 0, 2'd1, a, b, c, 0, '0, '0, '0, 2'd0, 1);
        end
        drain();

        // Stall: three beats fill the pipe with out_ready low, then hold 5 cycles.
        beat(0, 0, 2'd2, 16'h1111, 16'h3333, 16'h8888, 1, 16'h1111, 16'h3333, 16'h8888, 2'd2, 0);
        beat(0, 0, 2'd3, 16'h1111, 16'h3333, 16'h8888, 1, 16'hBBBB, 16'hCCCC, 16'h1111, 2'd3, 0);
        beat(0, 0, 2'd0, 16'h1111, 16'h3333, 16'h8888, 1, 16'h8888, 16'hCCCC, 16'h1111, 2'd0, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 16'(in_ready), 16'd0);
            chk("stall_out_valid", 16'(out_valid), 16'd1);
            chk("stall_y1", y1, 16'h1111);
            chk("stall_y3", y3, 16'h8888);
            chk("stall_out_mode", 16'(out_mode), 16'd2);
        end
        drain();

        // Reset with two beats in flight and the counter at 1.
        beat(1, 1, 2'd0, 16'h1111, 16'h3333, 16'h8888, 1, 16'h8888, 16'hCCCC, 16'h1111, 2'd0, 1);
        beat(0, 0, 2'd2, 16'h1111, 16'h3333, 16'h8888, 1, 16'h1111, 16'h3333, 16'h8888, 2'd2, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        q.delete();
        bcnt     = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
        chk("mid_rst_y1", y1, 16'h0);
        chk("mid_rst_y2", y2, 16'h0);
        chk("mid_rst_y3", y3, 16'h0);
        chk("mid_rst_out_mode", 16'(out_mode), 16'd0);
        beat(0, 1, 2'd3, 16'h1111, 16'h3333, 16'h8888, 1, 16'h8888, 16'hCCCC, 16'h1111, 2'd0, 1);
        drain();

        // Random traffic with random bubbles and backpressure.
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                in_valid  = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                beat($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                     16'($urandom), 16'($urandom), 16'($urandom), 0, '0, '0, '0, 2'd0, 2);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/masked_affine_pipe.md
Name: masked_affine_pipe

Overview:
- Parametrised, pipelined 3-share affine layer for the masked SKINNY S-box datapath.
- Applies one of four nibble-wise affine maps to every 4-bit nibble of NIBBLES parallel S-box lanes.
- The map is either selected explicitly or sequenced by an internal step counter across the S-box decomposition stages.
- Sits between the quadratic component stages; it adds valid/ready flow control and a configurable register depth.

Parameters:
- NIBBLES, 1, parallel 4-bit lanes per share (1..16).
- STAGES, 1, register stages between input and output (1..3).
- SEQ_LEN, 2, auto-sequence length; step index i selects mode i (1..4).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_first  input  1  beat is the first stage of a new S-box evaluation (auto mode only).
- mode_auto  input  1  1: mode from step counter; 0: mode from mode_sel.
- mode_sel  input  2  explicit mode.
- x1, x2, x3  input  4*NIBBLES  input shares.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- y1, y2, y3  output  4*NIBBLES  output shares.
- out_mode  output  2  mode applied to the current output beat.

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a clk edge clears all stage valid bits, data registers (y*=0, out_mode=0) and the step counter (cnt=0).
- Modes are applied per nibble; x[k] is bit k of the nibble.
  - Mode 0: y={x0,x1,x2,x3} on all shares.
  - Mode 1: y={x3,x2,x0,x1}; share 1 is complemented after permuting.
  - Mode 2: identity on all shares.
  - Mode 3: y={x1,x0,x2,x3}; share 1 is complemented.
- Complementing only share 1 keeps the unmasked value correct; shares are never mixed.
- Mode used on an accepted beat:
  - mode_auto=0: mode_sel.
  - mode_auto=1: 0 if in_first, else cnt.
- Step counter: on each accepted beat with mode_auto=1, cnt <= (used+1) mod SEQ_LEN. The counter holds otherwise, including on explicit-mode beats.
- Affine logic is combinational at the input. Its result and the mode tag enter stage 1; stages then shift in lockstep.
- Flow control:
  - en = out_ready | ~out_valid; in_ready = en.
  - Accept = in_valid & in_ready.
  - When en=1, every stage takes its predecessor's valid/data; stage 1 takes valid=accept.
  - When en=0, all stages hold.
- Latency: exactly STAGES cycles from accept to out_valid with no stall. Throughput is 1 beat/cycle while out_ready=1.
- Pipeline bubbles propagate as invalid; data in invalid slots is don't-care but still registered.
- out_valid=1 with out_ready=0 must hold y*/out_mode stable until the handshake.
- Beats are never dropped or duplicated; order is preserved.
- rst mid-operation discards all in-flight beats and resets cnt; in_ready is 1 in the cycle after reset.
- in_first=1 with mode_auto=0 is ignored.

Decomposition:
- Shared package skinny_mask_pkg holds:
  - 2-bit mode constants AFF_A1=0, AFF_A2=1, AFF_ID=2, AFF_A2A1=3.
  - SHARES=3.
  - Nibble width constant 4.
- Sub-module masked_affine_nibble is purely combinational. Inputs: mode, three 4-bit shares. Outputs: three 4-bit shares. It is instantiated NIBBLES times by a generate loop.
- The top level holds the step counter, mode mux and the STAGES-deep register pipeline.

Test Plan:
- NIBBLES=1, STAGES=1, explicit mode 0, x1=1, x2=3, x3=8, out_ready=1 -> next cycle out_valid=1, y1=8, y2=C, y3=1, out_mode=0.
- Explicit mode 1, x1=1, x2=1, x3=0 -> y1=D, y2=2, y3=0; check XOR of outputs equals mode-1 map of XOR of inputs for all 4096 share triples.
- mode_auto=1, SEQ_LEN=2, continuous beats with in_first=1,0,0,1,0 -> out_mode sequence 0,1,0,0,1.
- STAGES=3, out_ready held 0 for 5 cycles after 3 accepted beats -> in_ready=0 once out_valid=1; outputs stable; all three beats emerge in order when out_ready returns to 1.
- rst asserted with 2 beats in flight and cnt=1 -> next cycle out_valid=0, y*=0, out_mode=0; next auto beat without in_first uses mode 0.
- NIBBLES=4, random back-to-back traffic with random out_ready -> scoreboard matches golden per-nibble model; no loss, no duplication.
